adc_scan_sequencer: RTL and testbench

Controller for the 12-bit serial ADC interface. It scans a masked set of ADC channels in ascending order and issues one conversion request per sample to the SPI engine. For each channel it averages 2^AVG_LOG2 consecutive conversions and stores the result in a per-channel register bank. It sits between the SPI engine and the application logic, and publishes every result as a one-cycle strobe plus a random-access read port.

---
 rtl/adc_scan_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 562 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
// Scans a masked set of ADC channels in ascending order, issues one conversion
// request per sample to the SPI engine, averages 2^AVG_LOG2 samples per channel
// and stores each average in a per-channel result bank.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   enable         level; keep scanning pass after pass while high
//   single_shot    pulse; request exactly one pass (only honoured in IDLE)
//   ch_mask        channel enable mask, bit i = channel i
//   conv_start     one-cycle conversion request to the SPI engine
//   conv_channel   channel address of the current conversion
//   conv_done      one-cycle end-of-conversion strobe from the SPI engine
//   conv_data      sample, valid while conv_done is high
//   result_valid   one-cycle strobe, an averaged result is published
//   result_channel channel of the published result
//   result_data    averaged result
//   rd_channel     read-port address
//   rd_data        bank[rd_channel], combinational
//   scan_done      one-cycle strobe at the end of each pass
//   busy           high whenever the sequencer is not idle
//   timeout_err    sticky flag, a conversion never completed
//   err_clear      clears timeout_err (a new timeout wins over a clear)
module adc_scan_sequencer #(
  parameter int NUM_CH   = 8,
  parameter int CH_W     = 3,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              single_shot,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              conv_start,
  output logic [CH_W-1:0]   conv_channel,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] conv_data,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_channel,
  output logic [DATA_W-1:0] result_data,
  input  logic [CH_W-1:0]   rd_channel,
  output logic [DATA_W-1:0] rd_data,
  output logic              scan_done,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clear
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    WAIT,
    PUBLISH
  } state_t;

  state_t             state;
  logic [NUM_CH-1:0]  mask_q;
  logic [CH_W-1:0]    ptr;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [DATA_W-1:0]  bank [NUM_CH];

  logic [CH_W-1:0]    low_ptr;
  logic [CH_W-1:0]    next_ptr;
  logic               has_next;
  logic               mask_any;
  logic [ACC_W-1:0]   acc_sum;
  logic               last_sample;
  logic               tmo_hit;
  logic               advance;

  // Lowest set bit of the live mask (start of a new pass) and the next set
  // bit of the latched mask above the current channel. Both loops run from
  // the top down so the last hit is the lowest qualifying index.
  always_comb begin
    low_ptr  = '0;
    next_ptr = ptr;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        low_ptr = CH_W'(i);
      end
      if (mask_q[i] && (CH_W'(i) > ptr)) begin
        has_next = 1'b1;
        next_ptr = CH_W'(i);
      end
    end
  end

  assign mask_any    = |ch_mask;
  assign acc_sum     = acc + ACC_W'(conv_data);
  assign last_sample = (count == LAST_CNT);

  // A timeout only fires when the final allowed WAIT cycle passes without a
  // conv_done; a conv_done in that same cycle is still accepted.
  assign tmo_hit = (state == WAIT) && !conv_done && (tmo_cnt == TMO_LAST);

  // Leaving a channel happens after a publish or after a timeout skip.
  assign advance = (state == PUBLISH) || tmo_hit;

  assign busy    = (state != IDLE);

  // Reads see the bank contents before any write in the same cycle.
  assign rd_data = bank[rd_channel];

  // Main sequencer. Strobes default low every cycle; conv_start and
  // result_valid are set on the transition into START / PUBLISH so they are
  // high exactly while those states are current. The advance block at the
  // end overrides the per-state next state when a channel is finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mask_q         <= '0;
      ptr            <= '0;
      acc            <= '0;
      count          <= '0;
      tmo_cnt        <= '0;
      conv_start     <= 1'b0;
      conv_channel   <= '0;
      result_valid   <= 1'b0;
      result_channel <= '0;
      result_data    <= '0;
      scan_done      <= 1'b0;
      timeout_err    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      conv_start   <= 1'b0;
      result_valid <= 1'b0;
      scan_done    <= 1'b0;

      if (err_clear) begin
        timeout_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (mask_any && (enable || single_shot)) begin
            mask_q       <= ch_mask;
            ptr          <= low_ptr;
            conv_channel <= low_ptr;
            state        <= SELECT;
          end
        end

        SELECT: begin
          acc        <= '0;
          count      <= '0;
          conv_start <= 1'b1;
          state      <= START;
        end

        START: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end

        WAIT: begin
          if (conv_done) begin
            acc   <= acc_sum;
            count <= count + CNT_W'(1);
            if (last_sample) begin
              result_valid   <= 1'b1;
              result_channel <= ptr;
              result_data    <= DATA_W'(acc_sum >> AVG_LOG2);
              state          <= PUBLISH;
            end else begin
              conv_start <= 1'b1;
              state      <= START;
            end
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            acc         <= '0;
            count       <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        PUBLISH: begin
          bank[ptr] <= result_data;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Move to the next masked channel, or close the pass and either
      // restart from a freshly latched mask or go idle.
      if (advance) begin
        if (has_next) begin
          ptr          <= next_ptr;
          conv_channel <= next_ptr;
          state        <= SELECT;
        end else begin
          scan_done <= 1'b1;
          if (enable && mask_any) begin
            mask_q       <= ch_mask;
            ptr          <= low_ptr;
            conv_channel <= low_ptr;
            state        <= SELECT;
          end else begin
            state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer
// Directed bench for adc_scan_sequencer. A small SPI-engine stand-in answers
// each conv_start with conv_done after a programmable delay; a monitor logs
// every result, conversion request and end of pass with its cycle number.
// Each test task drives its scenario and compares against hand-computed values.
module tb_adc_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        single_shot;
  logic [7:0]  ch_mask;
  logic        conv_start;
  logic [2:0]  conv_channel;
  logic        conv_done;
  logic [11:0] conv_data;
  logic        result_valid;
  logic [2:0]  result_channel;
  logic [11:0] result_data;
  logic [2:0]  rd_channel;
  logic [11:0] rd_data;
  logic        scan_done;
  logic        busy;
  logic        timeout_err;
  logic        err_clear;

  logic        resp_done;
  logic        stray_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // SPI-engine stand-in controls
  bit          resp_en = 1'b1;
  int          resp_skip = -1;
  int          resp_delay = 2;
  bit          use_samp = 1'b0;
  logic [11:0] samp [4];
  logic [11:0] resp_default = 12'd0;
  int          samp_base = 0;
  int          resp_count = 0;
  int          last_done_cyc = -1;

  // Monitor logs
  int res_ch[$];
  int res_data[$];
  int res_cyc[$];
  int start_ch[$];
  int start_cyc[$];
  int scan_cyc[$];

  assign conv_done = resp_done | stray_done;

  adc_scan_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .single_shot    (single_shot),
    .ch_mask        (ch_mask),
    .conv_start     (conv_start),
    .conv_channel   (conv_channel),
    .conv_done      (conv_done),
    .conv_data      (conv_data),
    .result_valid   (result_valid),
    .result_channel (result_channel),
    .result_data    (result_data),
    .rd_channel     (rd_channel),
    .rd_data        (rd_data),
    .scan_done      (scan_done),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .err_clear      (err_clear)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time-stamp monitor events
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (result_valid) begin
      res_ch.push_back(int'(result_channel));
      res_data.push_back(int'(result_data));
      res_cyc.push_back(cyc);
    end
    if (conv_start) begin
      start_ch.push_back(int'(conv_channel));
      start_cyc.push_back(cyc);
    end
    if (scan_done) begin
      scan_cyc.push_back(cyc);
    end
  end

  // SPI-engine stand-in: answers conv_start after resp_delay cycles with the
  // next sample from samp[] or the constant resp_default
  initial begin
    resp_done = 1'b0;
    conv_data = 12'd0;
    forever begin
      @(negedge clk);
      if (conv_start && resp_en && (int'(conv_channel) != resp_skip)) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        conv_data     = use_samp ? samp[2'((resp_count - samp_base) % 4)] : resp_default;
        resp_done     = 1'b1;
        last_done_cyc = cyc;
        resp_count++;
        @(posedge clk);
        #1;
        resp_done = 1'b0;
      end
    end
  end

  // Advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_single_shot();
    single_shot = 1'b1;
    tick(1);
    single_shot = 1'b0;
  endtask

  // Wait (bounded) until the number of logged scan_done strobes reaches target
  task automatic wait_scans(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (scan_cyc.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    vectors++;
    if ({busy, conv_start, result_valid, scan_done, timeout_err} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, expected 00000",
               {busy, conv_start, result_valid, scan_done, timeout_err});
    end
    vectors++;
    if ({conv_channel, result_channel, result_data} !== 18'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got ch=%0d rch=%0d rdata=%0d, expected 0/0/0",
               conv_channel, result_channel, result_data);
    end
    for (int c = 0; c < 8; c += 7) begin
      rd_channel = 3'(c);
      #1;
      vectors++;
      if (rd_data !== 12'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_bank%0d: got %0d, expected 0", c, rd_data);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_averaging();
    int r0, s0, c0, bad;
    bit ok;
    r0 = res_ch.size();
    s0 = scan_cyc.size();
    c0 = start_ch.size();
    samp       = '{12'd2237, 12'd2239, 12'd2234, 12'd2231};
    samp_base  = resp_count;
    use_samp   = 1'b1;
    resp_delay = 3;
    ch_mask    = 8'h01;
    pulse_single_shot();
    wait_scans(s0 + 1, 400, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL avg_scan_done: got no scan_done within 400 cycles, expected one");
    end
    vectors++;
    if (start_ch.size() - c0 != 4) begin
      miscompares++;
      $display("[TB] FAIL avg_start_count: got %0d, expected 4", start_ch.size() - c0);
    end
    bad = 0;
    for (int i = c0; i < start_ch.size(); i++) if (start_ch[i] != 0) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL avg_start_channel: got %0d requests off channel 0, expected 0", bad);
    end
    vectors++;
    if (res_ch.size() - r0 != 1) begin
      miscompares++;
      $display("[TB] FAIL avg_result_count: got %0d, expected 1", res_ch.size() - r0);
    end else begin
      vectors++;
      if (res_ch[r0] != 0 || res_data[r0] != 2235) begin
        miscompares++;
        $display("[TB] FAIL avg_result: got ch=%0d data=%0d, expected ch=0 data=2235",
                 res_ch[r0], res_data[r0]);
      end
      vectors++;
      if (res_cyc[r0] != last_done_cyc + 1) begin
        miscompares++;
        $display("[TB] FAIL avg_result_latency: got %0d cycles, expected 1",
                 res_cyc[r0] - last_done_cyc);
      end
      if (ok) begin
        vectors++;
        if (scan_cyc[s0] != res_cyc[r0] + 1) begin
          miscompares++;
          $display("[TB] FAIL avg_scan_latency: got %0d cycles, expected 1",
                   scan_cyc[s0] - res_cyc[r0]);
        end
      end
    end
    tick(1);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL avg_busy_idle: got %b, expected 0", busy);
    end
    rd_channel = 3'd0;
    #1;
    vectors++;
    if (rd_data !== 12'd2235) begin
      miscompares++;
      $display("[TB] FAIL avg_read_port: got %0d, expected 2235", rd_data);
    end
    use_samp = 1'b0;
    tick(1);
  endtask

  task automatic test_masked_scan();
    int r0, s0, got;
    int exp_ch[4];
    bit ok;
    exp_ch       = '{2, 5, 7, 2};
    r0           = res_ch.size();
    s0           = scan_cyc.size();
    resp_default = 12'd100;
    resp_delay   = 2;
    ch_mask      = 8'b1010_0100;
    enable       = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (res_ch.size() >= r0 + 4) break;
    end
    enable = 1'b0;
    got = res_ch.size() - r0;
    vectors++;
    if (got < 4) begin
      miscompares++;
      $display("[TB] FAIL scan_result_count: got %0d, expected at least 4", got);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (res_ch[r0 + i] != exp_ch[i] || res_data[r0 + i] != 100) begin
          miscompares++;
          $display("[TB] FAIL scan_order%0d: got ch=%0d data=%0d, expected ch=%0d data=100",
                   i, res_ch[r0 + i], res_data[r0 + i], exp_ch[i]);
        end
      end
      vectors++;
      if (scan_cyc.size() <= s0 || scan_cyc[s0] != res_cyc[r0 + 2] + 1) begin
        miscompares++;
        $display("[TB] FAIL scan_done_after_ch7: got %0d strobes since start, expected first one 1 cycle after ch7",
                 scan_cyc.size() - s0);
      end
    end
    wait_scans(s0 + 2, 600, ok);
    tick(2);
    @(negedge clk);
    vectors++;
    if (ok !== 1'b1 || busy !== 1'b0 || res_ch.size() - r0 != 6) begin
      miscompares++;
      $display("[TB] FAIL scan_stop: got ok=%b busy=%b results=%0d, expected 1/0/6",
               ok, busy, res_ch.size() - r0);
    end
  endtask

  task automatic test_timeout();
    int r0, s0, c0, err_cyc, delta;
    bit got, ok;
    r0           = res_ch.size();
    s0           = scan_cyc.size();
    c0           = start_ch.size();
    resp_skip    = 0;
    resp_default = 12'd500;
    resp_delay   = 2;
    ch_mask      = 8'h03;
    // err_clear held high across the timeout: the set must still win
    err_clear    = 1'b1;
    pulse_single_shot();
    got = 1'b0;
    err_cyc = 0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        got = 1'b1;
        err_cyc = cyc;
        break;
      end
    end
    err_clear = 1'b0;
    vectors++;
    if (got !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL tmo_flag: got timeout_err=0 after 1300 cycles, expected 1");
    end else begin
      delta = err_cyc - start_cyc[c0];
      // Allow for where the count is considered to begin around conv_start
      vectors++;
      if (delta < 1023 || delta > 1025) begin
        miscompares++;
        $display("[TB] FAIL tmo_latency: got %0d cycles, expected 1023..1025", delta);
      end
    end
    wait_scans(s0 + 1, 300, ok);
    vectors++;
    if (ok !== 1'b1 || start_ch.size() - c0 < 2 || start_ch[c0] != 0 || start_ch[c0 + 1] != 1) begin
      miscompares++;
      $display("[TB] FAIL tmo_skip: got ok=%b requests=%0d, expected ok=1 with ch0 once then ch1",
               ok, start_ch.size() - c0);
    end
    vectors++;
    if (res_ch.size() - r0 != 1 || res_ch[r0] != 1 || res_data[r0] != 500) begin
      miscompares++;
      $display("[TB] FAIL tmo_results: got %0d results, expected exactly ch1=500",
               res_ch.size() - r0);
    end
    tick(5);
    vectors++;
    if (timeout_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL tmo_sticky: got %b, expected 1", timeout_err);
    end
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    @(negedge clk);
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tmo_clear: got %b, expected 0", timeout_err);
    end
    resp_skip = -1;
    tick(1);
  endtask

  task automatic test_mid_pass();
    int r0, s0, r1, s1;
    bit ok;
    r0           = res_ch.size();
    s0           = scan_cyc.size();
    resp_default = 12'd300;
    resp_delay   = 2;
    ch_mask      = 8'h07;
    enable       = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (res_ch.size() >= r0 + 1) break;
    end
    // Four cycles after channel 0 publishes, channel 1 is in its first WAIT
    tick(4);
    ch_mask = 8'h80;
    enable  = 1'b0;
    wait_scans(s0 + 1, 400, ok);
    tick(2);
    @(negedge clk);
    vectors++;
    if (ok !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_end_of_pass: got ok=%b busy=%b, expected 1/0", ok, busy);
    end
    vectors++;
    if (res_ch.size() - r0 != 3 || res_ch[r0] != 0 || res_ch[r0 + 1] != 1 || res_ch[r0 + 2] != 2) begin
      miscompares++;
      $display("[TB] FAIL mid_channels: got %0d results, expected channels 0,1,2",
               res_ch.size() - r0);
    end
    r1 = res_ch.size();
    s1 = scan_cyc.size();
    tick(1);
    pulse_single_shot();
    wait_scans(s1 + 1, 200, ok);
    vectors++;
    if (ok !== 1'b1 || res_ch.size() - r1 != 1 || res_ch[r1] != 7 || res_data[r1] != 300) begin
      miscompares++;
      $display("[TB] FAIL mid_new_mask: got ok=%b results=%0d, expected one result ch7=300",
               ok, res_ch.size() - r1);
    end
    tick(2);
  endtask

  task automatic test_reset_mid();
    int r0, s0, bad;
    rd_channel = 3'd7;
    #1;
    vectors++;
    if (rd_data !== 12'd300) begin
      miscompares++;
      $display("[TB] FAIL rstmid_bank_before: got %0d, expected 300", rd_data);
    end
    resp_en = 1'b0;
    ch_mask = 8'h01;
    pulse_single_shot();
    tick(6);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_busy_before: got %b, expected 1", busy);
    end
    r0 = res_ch.size();
    s0 = scan_cyc.size();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || conv_start !== 1'b0 || rd_data !== 12'd0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_cleared: got busy=%b start=%b bank7=%0d, expected 0/0/0",
               busy, conv_start, rd_data);
    end
    tick(1);
    stray_done = 1'b1;
    tick(1);
    stray_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || result_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0 || res_ch.size() != r0 || scan_cyc.size() != s0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_stray: got %0d active cycles, %0d results, %0d scan_done, expected 0/0/0",
               bad, res_ch.size() - r0, scan_cyc.size() - s0);
    end
    resp_en = 1'b1;
    tick(1);
  endtask

  task automatic test_edges();
    int s0, r0, bad;
    bit ok, seen;
    ch_mask = 8'h00;
    pulse_single_shot();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL edge_empty_mask: got busy in %0d cycles, expected 0", bad);
    end

    tick(1);
    samp       = '{12'd4095, 12'd4095, 12'd4095, 12'd4095};
    samp_base  = resp_count;
    use_samp   = 1'b1;
    resp_delay = 1;
    ch_mask    = 8'h08;
    rd_channel = 3'd3;
    s0 = scan_cyc.size();
    pulse_single_shot();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (seen !== 1'b1 || result_channel !== 3'd3 || result_data !== 12'd4095) begin
      miscompares++;
      $display("[TB] FAIL edge_max: got seen=%b ch=%0d data=%0d, expected 1/3/4095",
               seen, result_channel, result_data);
    end
    vectors++;
    if (rd_data !== 12'd0) begin
      miscompares++;
      $display("[TB] FAIL edge_read_old: got %0d, expected 0", rd_data);
    end
    @(negedge clk);
    vectors++;
    if (rd_data !== 12'd4095) begin
      miscompares++;
      $display("[TB] FAIL edge_read_new: got %0d, expected 4095", rd_data);
    end
    wait_scans(s0 + 1, 50, ok);
    tick(1);

    samp      = '{12'd0, 12'd0, 12'd0, 12'd3};
    samp_base = resp_count;
    ch_mask   = 8'h10;
    r0 = res_ch.size();
    s0 = scan_cyc.size();
    pulse_single_shot();
    wait_scans(s0 + 1, 300, ok);
    vectors++;
    if (ok !== 1'b1 || res_ch.size() - r0 != 1 || res_ch[r0] != 4 || res_data[r0] != 0) begin
      miscompares++;
      $display("[TB] FAIL edge_truncate: got ok=%b results=%0d, expected one result ch4=0",
               ok, res_ch.size() - r0);
    end
    rd_channel = 3'd4;
    #1;
    vectors++;
    if (rd_data !== 12'd0) begin
      miscompares++;
      $display("[TB] FAIL edge_truncate_read: got %0d, expected 0", rd_data);
    end
    use_samp = 1'b0;
    tick(2);
  endtask

  // Run every scenario in order, then report
  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    single_shot = 1'b0;
    err_clear   = 1'b0;
    ch_mask     = 8'h00;
    rd_channel  = 3'd0;
    stray_done  = 1'b0;
    test_reset();
    test_averaging();
    test_masked_scan();
    test_timeout();
    test_mid_pass();
    test_reset_mid();
    test_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
